// File: rtl/cdb_wb_arbiter_if.sv
// Functional-unit result handshake and common-data-bus broadcast bundle.
// master = result producers and bus consumers; slave = the arbiter.
interface cdb_wb_arbiter_if #(
   parameter int NUM_REQ       = 5,
   parameter int PHYS_REG_BITS = 6,
   parameter int ROB_NUM_BITS  = 4
);
   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ*5-1:0]             req_rd_addr;
   logic [NUM_REQ*PHYS_REG_BITS-1:0] req_rd_paddr;
   logic [NUM_REQ*32-1:0]            req_rd_data;
   logic [NUM_REQ*ROB_NUM_BITS-1:0]  req_rob_addr;
   logic [NUM_REQ-1:0]               req_ready;

   logic                             cdb_valid;
   logic [4:0]                       cdb_rd_addr;
   logic [PHYS_REG_BITS-1:0]         cdb_rd_paddr;
   logic [31:0]                      cdb_rd_data;
   logic [ROB_NUM_BITS-1:0]          cdb_rob_addr;
   logic [31:0]                      cdb_conflict_cnt;

   modport master (
      output req_valid, req_rd_addr, req_rd_paddr, req_rd_data, req_rob_addr,
      input  req_ready,
      input  cdb_valid, cdb_rd_addr, cdb_rd_paddr, cdb_rd_data, cdb_rob_addr,
      input  cdb_conflict_cnt
   );

   modport slave (
      input  req_valid, req_rd_addr, req_rd_paddr, req_rd_data, req_rob_addr,
      output req_ready,
      output cdb_valid, cdb_rd_addr, cdb_rd_paddr, cdb_rd_data, cdb_rob_addr,
      output cdb_conflict_cnt
   );
endinterface

// File: rtl/cdb_wb_arbiter.sv
// Round-robin common-data-bus arbiter with a registered one-cycle broadcast.
// Optional contention counter enabled by defining CDB_CONFLICT_CNT_EN.
module cdb_wb_arbiter #(
   parameter int NUM_REQ       = 5,
   parameter int PHYS_REG_BITS = 6,
   parameter int ROB_NUM_BITS  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   cdb_wb_arbiter_if.slave            bus,
   output logic [$clog2(NUM_REQ)-1:0] dbg_rr_ptr_o
);
   localparam int PTR_W = $clog2(NUM_REQ);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   // Handshake: unit i transfers when req_valid[i] && req_ready[i]; req_ready is
   // combinational, at most one-hot, and low during rst or flush.
   logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
   logic                     cdb_valid_q, cdb_valid_d;
   logic [4:0]               cdb_rd_addr_q, cdb_rd_addr_d;
   logic [PHYS_REG_BITS-1:0] cdb_rd_paddr_q, cdb_rd_paddr_d;
   logic [31:0]              cdb_rd_data_q, cdb_rd_data_d;
   logic [ROB_NUM_BITS-1:0]  cdb_rob_addr_q, cdb_rob_addr_d;

   logic                     found;
   logic [PTR_W-1:0]         gnt_idx;
   logic [PTR_W:0]           sum;
   logic [PTR_W-1:0]         idx;
   logic                     xfer;
   logic [NUM_REQ-1:0]       grant;
   logic [4:0]               sel_rd_addr;
   logic [PHYS_REG_BITS-1:0] sel_rd_paddr;
   logic [31:0]              sel_rd_data;
   logic [ROB_NUM_BITS-1:0]  sel_rob_addr;

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
         idx = sum[PTR_W-1:0];
         if (!found && bus.req_valid[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   assign xfer = found && !rst && !flush;

   always_comb begin
      grant = '0;
      if (xfer) grant[gnt_idx] = 1'b1;
   end

   assign sel_rd_addr  = bus.req_rd_addr [int'(gnt_idx)*5 +: 5];
   assign sel_rd_paddr = bus.req_rd_paddr[int'(gnt_idx)*PHYS_REG_BITS +: PHYS_REG_BITS];
   assign sel_rd_data  = bus.req_rd_data [int'(gnt_idx)*32 +: 32];
   assign sel_rob_addr = bus.req_rob_addr[int'(gnt_idx)*ROB_NUM_BITS +: ROB_NUM_BITS];

   always_comb begin
      rr_ptr_d       = rr_ptr_q;
      cdb_valid_d    = xfer;
      cdb_rd_addr_d  = cdb_rd_addr_q;
      cdb_rd_paddr_d = cdb_rd_paddr_q;
      cdb_rd_data_d  = cdb_rd_data_q;
      cdb_rob_addr_d = cdb_rob_addr_q;
      if (xfer) begin
         rr_ptr_d       = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
         cdb_rd_addr_d  = sel_rd_addr;
         cdb_rd_paddr_d = sel_rd_paddr;
         // x0 results still complete in the ROB but must never carry data.
         cdb_rd_data_d  = (sel_rd_addr == 5'd0) ? 32'd0 : sel_rd_data;
         cdb_rob_addr_d = sel_rob_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q       <= '0;
         cdb_valid_q    <= 1'b0;
         cdb_rd_addr_q  <= '0;
         cdb_rd_paddr_q <= '0;
         cdb_rd_data_q  <= '0;
         cdb_rob_addr_q <= '0;
      end else begin
         rr_ptr_q       <= rr_ptr_d;
         cdb_valid_q    <= cdb_valid_d;
         cdb_rd_addr_q  <= cdb_rd_addr_d;
         cdb_rd_paddr_q <= cdb_rd_paddr_d;
         cdb_rd_data_q  <= cdb_rd_data_d;
         cdb_rob_addr_q <= cdb_rob_addr_d;
      end
   end

   // A flush squashes the broadcast registered in the cycle before it.
   assign bus.cdb_valid    = cdb_valid_q && !flush;
   assign bus.req_ready    = grant;
   assign bus.cdb_rd_addr  = cdb_rd_addr_q;
   assign bus.cdb_rd_paddr = cdb_rd_paddr_q;
   assign bus.cdb_rd_data  = cdb_rd_data_q;
   assign bus.cdb_rob_addr = cdb_rob_addr_q;
   assign dbg_rr_ptr_o     = rr_ptr_q;

`ifdef CDB_CONFLICT_CNT_EN
   logic [31:0] conflict_cnt_q, conflict_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (!flush && ($countones(bus.req_valid) >= 2) && (conflict_cnt_q != 32'hFFFF_FFFF))
         conflict_cnt_d = conflict_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) conflict_cnt_q <= '0;
      else     conflict_cnt_q <= conflict_cnt_d;
   end

   assign bus.cdb_conflict_cnt = conflict_cnt_q;
`else
   assign bus.cdb_conflict_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed table-driven bench for cdb_wb_arbiter: grant order, broadcast
// payload, flush squash, x0 handling, reset and the optional conflict counter.
module tb_cdb_wb_arbiter;
   localparam int W = 47;

`ifdef CDB_CONFLICT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   typedef struct {
      logic       flush;
      logic [4:0] valid;
      logic [4:0] exp_ready;
      logic       exp_cdb_valid;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [2:0] dbg_rr_ptr;

   always #5 clk = ~clk;

   cdb_wb_arbiter_if #(.NUM_REQ(5), .PHYS_REG_BITS(6), .ROB_NUM_BITS(4)) bus ();

   cdb_wb_arbiter #(.NUM_REQ(5), .PHYS_REG_BITS(6), .ROB_NUM_BITS(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .bus          (bus),
      .dbg_rr_ptr_o (dbg_rr_ptr)
   );

   logic [4:0]   p_rd [5];
   logic [5:0]   p_pa [5];
   logic [31:0]  p_dt [5];
   logic [3:0]   p_rb [5];
   logic [W-1:0] exp_q[$];
   logic [31:0]  exp_cnt;
   int           n_total;
   int           n_pass;
   vec_t         vecs [21];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic drive_payload();
      for (int i = 0; i < 5; i++) begin
         bus.req_rd_addr [i*5 +: 5]  = p_rd[i];
         bus.req_rd_paddr[i*6 +: 6]  = p_pa[i];
         bus.req_rd_data [i*32 +: 32] = p_dt[i];
         bus.req_rob_addr[i*4 +: 4]  = p_rb[i];
      end
   endtask

   task automatic check_broadcast(input string nm);
      logic [W-1:0] e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({nm, " cdb_rd_addr"},  64'(bus.cdb_rd_addr),  64'(e[46:42]));
         chk({nm, " cdb_rd_paddr"}, 64'(bus.cdb_rd_paddr), 64'(e[41:36]));
         chk({nm, " cdb_rd_data"},  64'(bus.cdb_rd_data),  64'(e[35:4]));
         chk({nm, " cdb_rob_addr"}, 64'(bus.cdb_rob_addr), 64'(e[3:0]));
      end
   endtask

   task automatic step(input string nm, input logic fl, input logic [4:0] vld,
                       input logic [4:0] exp_rdy, input logic exp_v);
      @(negedge clk);
      rst           = 1'b0;
      flush         = fl;
      bus.req_valid = vld;
      drive_payload();
      #1;
      chk({nm, " req_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
      chk({nm, " cdb_valid"}, 64'(bus.cdb_valid), 64'(exp_v));
      check_broadcast(nm);
      chk({nm, " conflict_cnt"}, 64'(bus.cdb_conflict_cnt), 64'(exp_cnt));
      for (int i = 0; i < 5; i++)
         if (exp_rdy[i])
            exp_q.push_back({p_rd[i], p_pa[i], (p_rd[i] == 5'd0) ? 32'd0 : p_dt[i], p_rb[i]});
      if (CNT_EN && !fl && ($countones(vld) >= 2)) exp_cnt = exp_cnt + 32'd1;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      exp_cnt = 32'd0;
      for (int i = 0; i < 5; i++) begin
         p_rd[i] = '0; p_pa[i] = '0; p_dt[i] = '0; p_rb[i] = '0;
      end

      //            flush  valid     exp_ready exp_cdb_valid
      vecs[0]  = '{1'b0, 5'b11111, 5'b00001, 1'b0};
      vecs[1]  = '{1'b0, 5'b11111, 5'b00010, 1'b1};
      vecs[2]  = '{1'b0, 5'b11111, 5'b00100, 1'b1};
      vecs[3]  = '{1'b0, 5'b11111, 5'b01000, 1'b1};
      vecs[4]  = '{1'b0, 5'b11111, 5'b10000, 1'b1};
      vecs[5]  = '{1'b0, 5'b11111, 5'b00001, 1'b1};
      vecs[6]  = '{1'b0, 5'b00000, 5'b00000, 1'b1};
      vecs[7]  = '{1'b0, 5'b01000, 5'b01000, 1'b0};
      vecs[8]  = '{1'b0, 5'b00101, 5'b00001, 1'b1};
      vecs[9]  = '{1'b0, 5'b00101, 5'b00100, 1'b1};
      vecs[10] = '{1'b0, 5'b00101, 5'b00001, 1'b1};
      vecs[11] = '{1'b1, 5'b00010, 5'b00000, 1'b0};
      vecs[12] = '{1'b0, 5'b00010, 5'b00010, 1'b0};
      vecs[13] = '{1'b0, 5'b00000, 5'b00000, 1'b1};
      vecs[14] = '{1'b0, 5'b00001, 5'b00001, 1'b0};
      vecs[15] = '{1'b0, 5'b00001, 5'b00001, 1'b1};
      vecs[16] = '{1'b0, 5'b10010, 5'b00010, 1'b1};
      vecs[17] = '{1'b0, 5'b10010, 5'b10000, 1'b1};
      vecs[18] = '{1'b0, 5'b00000, 5'b00000, 1'b1};
      vecs[19] = '{1'b1, 5'b11111, 5'b00000, 1'b0};
      vecs[20] = '{1'b0, 5'b00000, 5'b00000, 1'b0};

      // Reset held two cycles with every unit requesting.
      rst           = 1'b1;
      flush         = 1'b0;
      bus.req_valid = 5'b11111;
      drive_payload();
      @(negedge clk); #1;
      chk("reset0 req_ready", 64'(bus.req_ready), 64'd0);
      @(negedge clk); #1;
      chk("reset1 req_ready", 64'(bus.req_ready), 64'd0);
      chk("reset cdb_valid", 64'(bus.cdb_valid), 64'd0);
      chk("reset rr_ptr", 64'(dbg_rr_ptr), 64'd0);
      chk("reset cdb_rd_data", 64'(bus.cdb_rd_data), 64'd0);
      chk("reset conflict_cnt", 64'(bus.cdb_conflict_cnt), 64'd0);

      for (int k = 0; k < 21; k++) begin
         for (int i = 0; i < 5; i++) begin
            p_rd[i] = 5'((i*7 + k) % 31 + 1);
            p_pa[i] = 6'(i*10 + k);
            p_dt[i] = 32'hA000_0000 + 32'(k*16 + i);
            p_rb[i] = 4'(i + k);
         end
         step($sformatf("vec%0d", k), vecs[k].flush, vecs[k].valid,
              vecs[k].exp_ready, vecs[k].exp_cdb_valid);
      end

      // x0 destination: br result with rd=0 must broadcast with zero data.
      for (int i = 0; i < 5; i++) begin
         p_rd[i] = '0; p_pa[i] = '0; p_dt[i] = '0; p_rb[i] = '0;
      end
      p_rd[4] = 5'd0;  p_pa[4] = 6'd17; p_dt[4] = 32'h1234;      p_rb[4] = 4'd9;
      step("x0_br", 1'b0, 5'b10000, 5'b10000, 1'b0);

      p_rd[3] = 5'd5;  p_pa[3] = 6'd33; p_dt[3] = 32'hDEADBEEF;  p_rb[3] = 4'd7;
      step("single_mem", 1'b0, 5'b01000, 5'b01000, 1'b1);

      p_rd[0] = 5'd3;  p_pa[0] = 6'd2;  p_dt[0] = 32'h5555_AAAA; p_rb[0] = 4'd1;
      step("alu_after_mem", 1'b0, 5'b00001, 5'b00001, 1'b1);

      // Reset mid-operation drops the pending broadcast and restarts at alu.
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst req_ready", 64'(bus.req_ready), 64'd0);
      chk("midrst cdb_valid_before", 64'(bus.cdb_valid), 64'd1);
      check_broadcast("midrst");
      @(negedge clk); #1;
      chk("midrst cdb_valid_after", 64'(bus.cdb_valid), 64'd0);
      chk("midrst rr_ptr", 64'(dbg_rr_ptr), 64'd0);
      chk("midrst cdb_rd_data", 64'(bus.cdb_rd_data), 64'd0);
      chk("midrst conflict_cnt", 64'(bus.cdb_conflict_cnt), 64'd0);
      exp_cnt = 32'd0;
      step("post_midrst", 1'b0, 5'b00100, 5'b00100, 1'b0);
      step("post_midrst_bcast", 1'b0, 5'b00000, 5'b00000, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/cdb_wb_arbiter.md
Name: cdb_wb_arbiter

Overview:
- Arbitrates the single common data bus (CDB) between the out-of-order functional units: alu, mult, div, mem and br.
- Each unit offers one completed result per cycle over a valid/ready handshake.
- The arbiter grants one unit per cycle using round-robin priority and drives a registered broadcast in wb_bus_t layout plus the ROB index.
- Sits between the functional-unit outputs and the reservation stations, ROB and physical regfile.

Parameters:
- NUM_REQ, 5, number of requesting units; index 0=alu, 1=mult, 2=div, 3=mem, 4=br.
- PHYS_REG_BITS, 6, physical register tag width (matches package).
- ROB_NUM_BITS, 4, ROB index width (matches package).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  pipeline flush (branch mispredict).
- req_valid  in  NUM_REQ  per-unit result valid.
- req_rd_addr  in  NUM_REQ*5  architectural rd, slice i at [5i+:5].
- req_rd_paddr  in  NUM_REQ*PHYS_REG_BITS  physical rd tag.
- req_rd_data  in  NUM_REQ*32  result data.
- req_rob_addr  in  NUM_REQ*ROB_NUM_BITS  ROB entry of the result.
- req_ready  out  NUM_REQ  one-hot grant; the unit's transfer completes this cycle.
- cdb_valid  out  1  broadcast valid.
- cdb_rd_addr  out  5  broadcast architectural rd.
- cdb_rd_paddr  out  PHYS_REG_BITS  broadcast physical tag.
- cdb_rd_data  out  32  broadcast data.
- cdb_rob_addr  out  ROB_NUM_BITS  broadcast ROB index.
- cdb_conflict_cnt  out  32  contention counter; see Optional Feature.

Behaviour:
- Reset:
  - cdb_valid=0; cdb_rd_addr, cdb_rd_paddr, cdb_rd_data, cdb_rob_addr=0.
  - Round-robin pointer rr_ptr=0; cdb_conflict_cnt=0.
  - req_ready=0 during the reset cycle.
- Handshake:
  - Transfer for unit i occurs when req_valid[i] && req_ready[i].
  - A unit holds valid and payload stable until its transfer.
  - req_ready is combinational from req_valid, rr_ptr and flush.
  - req_ready is at most one-hot and never asserted for an invalid requester.
- Grant: search indices rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ. The first valid requester wins.
- Pointer update: on a transfer by unit g, rr_ptr <= (g+1) mod NUM_REQ next cycle. With no transfer, rr_ptr holds.
- Output register, latency 1:
  - The granted payload appears on the cdb_* outputs the cycle after the transfer, with cdb_valid=1.
  - With no transfer, cdb_valid=0 next cycle; payload fields hold their previous values.
- The CDB has no backpressure. Every consumer samples the broadcast each cycle.
- x0 rule: if the granted rd_addr==0, the broadcast still occurs (the ROB must see completion) but cdb_rd_data is forced to 0.
- Flush:
  - In the flush cycle, req_ready is all 0 and no transfer occurs.
  - Next cycle cdb_valid=0, including when a transfer was latched the previous cycle; that registered broadcast is squashed.
  - rr_ptr is unchanged.
  - Units are responsible for dropping their own squashed results.
- Simultaneous flush and rst: rst dominates.
- rst mid-operation: all state returns to reset values next edge. A pending result is lost.
- Throughput: one result per cycle sustained. A lone valid requester is granted every cycle.
- Fairness: a requester that stays valid is granted within NUM_REQ cycles.

Optional Feature:
- Macro: CDB_CONFLICT_CNT_EN.
- Defined:
  - cdb_conflict_cnt increments by 1 on every non-flush, non-reset cycle in which popcount(req_valid) >= 2, i.e. at least one valid unit is not granted.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst.
- Undefined: cdb_conflict_cnt tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset: hold rst 2 cycles with all req_valid=1 -> req_ready=0 during reset, cdb_valid=0, rr_ptr=0. First post-reset grant is alu (req_ready=5'b00001).
- Single requester: mem only valid, rd_addr=5, paddr=6'd33, data=32'hDEADBEEF, rob=4'd7 -> req_ready[3]=1 the same cycle. Next cycle cdb_valid=1 with exactly those values.
- Round-robin: all 5 valid and held continuously -> grant sequence alu, mult, div, mem, br, alu. cdb_valid=1 every cycle; with CDB_CONFLICT_CNT_EN, cdb_conflict_cnt=5 after 5 cycles.
- Wrap and skip: rr_ptr=4 (after a mem grant); only alu and div valid -> alu granted, then div, then alu.
- Flush: alu transfers in cycle N, flush=1 in cycle N+1 with mult valid -> cdb_valid=0 in N+1 (cycle N's registered result squashed) and N+2; req_ready=0 in N+1. Mult is granted in N+2 when flush=0.
- x0 write: br valid with rd_addr=0, data=32'h1234 -> cdb_valid=1 next cycle, cdb_rd_addr=0, cdb_rd_data=0, cdb_rob_addr passed through unchanged.
